// File: rtl/register_rename_stage.sv
// Register rename stage: 32-entry RAT plus circular free list of PHYS_REGS-32 physical registers.
// Optional macro RENAME_X0_BYPASS_EN: in_rd==0 never allocates and keeps RAT[0] fixed.
module register_rename_stage #(
    parameter int PHYS_REGS = 64,
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [4:0]    in_rd,
    input  logic          in_rd_wen,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_prs1,
    output logic [PW-1:0] out_prs2,
    output logic [PW-1:0] out_prd,
    output logic [PW-1:0] out_old_prd,
    output logic          out_rd_wen,
    input  logic          free_valid,
    input  logic [PW-1:0] free_preg,
    output logic [PW-1:0] free_count
);

    localparam int DEPTH = PHYS_REGS - 32;
    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   DEPTH_C = PW'(DEPTH);
    localparam logic [PTRW-1:0] LAST_C  = PTRW'(DEPTH - 1);

    logic [PW-1:0]   r_rat [32];
    logic [PW-1:0]   r_fl  [DEPTH];
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [PW-1:0]   r_count;

    logic            r_out_valid;
    logic [PW-1:0]   r_out_prs1;
    logic [PW-1:0]   r_out_prs2;
    logic [PW-1:0]   r_out_prd;
    logic [PW-1:0]   r_out_old_prd;
    logic            r_out_rd_wen;

    logic            w_alloc_needed;
    logic            w_out_load;
    logic            w_accept;
    logic            w_alloc;
    logic            w_push;
    logic [PW-1:0]   w_head_preg;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

`ifdef RENAME_X0_BYPASS_EN
    assign w_alloc_needed = in_rd_wen && (in_rd != 5'd0);
`else
    assign w_alloc_needed = in_rd_wen;
`endif

    assign w_out_load  = !r_out_valid || out_ready;
    assign in_ready    = w_out_load && (!w_alloc_needed || (r_count != '0));
    assign w_accept    = in_valid && in_ready;
    assign w_alloc     = w_accept && w_alloc_needed;
    // A full list only takes a returned register when an allocation frees a slot the same edge.
    assign w_push      = free_valid && ((r_count != DEPTH_C) || w_alloc);
    assign w_head_preg = r_fl[r_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rat[i] <= PW'(i);
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_fl[i] <= PW'(32 + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= DEPTH_C;
        end else begin
            if (w_alloc) begin
                r_rat[in_rd] <= w_head_preg;
                r_head       <= ptr_inc(r_head);
            end
            if (w_push) begin
                r_fl[r_tail] <= free_preg;
                r_tail       <= ptr_inc(r_tail);
            end
            case ({w_alloc, w_push})
                2'b10:   r_count <= r_count - 1'b1;
                2'b01:   r_count <= r_count + 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register stage: sources read from the RAT before this instruction's own update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_prs1    <= '0;
            r_out_prs2    <= '0;
            r_out_prd     <= '0;
            r_out_old_prd <= '0;
            r_out_rd_wen  <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_prs1    <= r_rat[in_rs1];
                r_out_prs2    <= r_rat[in_rs2];
                r_out_prd     <= w_alloc ? w_head_preg : '0;
                r_out_old_prd <= r_rat[in_rd];
                r_out_rd_wen  <= w_alloc_needed;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_prs1    = r_out_prs1;
    assign out_prs2    = r_out_prs2;
    assign out_prd     = r_out_prd;
    assign out_old_prd = r_out_old_prd;
    assign out_rd_wen  = r_out_rd_wen;
    assign free_count  = r_count;

endmodule

// File: tb/tb_register_rename_stage.sv
// Directed bench for register_rename_stage with a RAT/free-list reference model and expected-result queue.
module tb_register_rename_stage;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rs1, in_rs2, in_rd;
    logic       in_rd_wen;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_prs1, out_prs2, out_prd, out_old_prd;
    logic       out_rd_wen;
    logic       free_valid;
    logic [5:0] free_preg;
    logic [5:0] free_count;

    register_rename_stage #(.PHYS_REGS(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_old_prd(out_old_prd), .out_rd_wen(out_rd_wen),
        .free_valid(free_valid), .free_preg(free_preg), .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int prs1;
        int prs2;
        int prd;
        int old_prd;
        int wen;
    } exp_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_rat[32];
    int   m_fl[$];
    exp_t exp_q[$];
    exp_t last_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = i;
        m_fl.delete();
        for (int i = 0; i < DEPTH; i++) m_fl.push_back(32 + i);
        exp_q.delete();
    endtask

    task automatic model_accept(input int rs1, input int rs2, input int rd, input int wen,
                                output int alloc);
        exp_t e;
        alloc = wen;
`ifdef RENAME_X0_BYPASS_EN
        if (rd == 0) alloc = 0;
`endif
        e.prs1    = m_rat[rs1];
        e.prs2    = m_rat[rs2];
        e.old_prd = m_rat[rd];
        e.wen     = alloc;
        if (alloc != 0) begin
            e.prd = m_fl.pop_front();
            m_rat[rd] = e.prd;
        end else begin
            e.prd = 0;
        end
        exp_q.push_back(e);
    endtask

    task automatic set_in(input int v, input int rs1, input int rs2, input int rd, input int wen);
        in_valid  = (v != 0);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_rd     = 5'(rd);
        in_rd_wen = (wen != 0);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        last_exp = e;
        chk({tag, "_out_valid"},   out_valid,   1);
        chk({tag, "_out_prs1"},    out_prs1,    e.prs1);
        chk({tag, "_out_prs2"},    out_prs2,    e.prs2);
        chk({tag, "_out_prd"},     out_prd,     e.prd);
        chk({tag, "_out_old_prd"}, out_old_prd, e.old_prd);
        chk({tag, "_out_rd_wen"},  out_rd_wen,  e.wen);
        chk({tag, "_free_count"},  free_count,  m_fl.size());
    endtask

    task automatic issue(input string tag, input int rs1, input int rs2, input int rd, input int wen,
                         input int fv, input int fp);
        int sz0, alloc;
        set_in(1, rs1, rs2, rd, wen);
        free_valid = (fv != 0);
        free_preg  = 6'(fp);
        out_ready  = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        sz0 = m_fl.size();
        model_accept(rs1, rs2, rd, wen, alloc);
        if (fv != 0 && (sz0 < DEPTH || alloc != 0)) m_fl.push_back(fp);
        tick();
        in_valid   = 1'b0;
        free_valid = 1'b0;
        check_out(tag);
    endtask

    task automatic free_only(input string tag, input int p);
        in_valid   = 1'b0;
        free_valid = 1'b1;
        free_preg  = 6'(p);
        if (m_fl.size() < DEPTH) m_fl.push_back(p);
        tick();
        free_valid = 1'b0;
        chk({tag, "_free_count"}, free_count, m_fl.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int alloc;
        int k;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        out_ready  = 1'b1;
        free_valid = 1'b0;
        free_preg  = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        #1;

        chk("rst_out_valid",   out_valid,   0);
        chk("rst_out_prs1",    out_prs1,    0);
        chk("rst_out_prd",     out_prd,     0);
        chk("rst_out_old_prd", out_old_prd, 0);
        chk("rst_out_rd_wen",  out_rd_wen,  0);
        chk("rst_free_count",  free_count,  32);
        chk("rst_in_ready",    in_ready,    1);

        issue("t1", 3, 4, 5, 1, 0, 0);
        chk("t1_prd_const",   out_prd,     32);
        chk("t1_old_const",   out_old_prd, 5);
        chk("t1_count_const", free_count,  31);

        issue("t2", 5, 0, 5, 1, 0, 0);
        chk("t2_prs1_const",  out_prs1,    32);
        chk("t2_prd_const",   out_prd,     33);
        chk("t2_old_const",   out_old_prd, 32);
        chk("t2_count_const", free_count,  30);

        issue("t3_nowen", 5, 6, 9, 0, 0, 0);
        chk("t3_prd_zero", out_prd, 0);

        issue("x0", 0, 0, 0, 1, 0, 0);
`ifdef RENAME_X0_BYPASS_EN
        chk("x0_prd_const",   out_prd,    0);
        chk("x0_wen_const",   out_rd_wen, 0);
        chk("x0_count_const", free_count, 30);
`else
        chk("x0_prd_const",   out_prd,    34);
        chk("x0_wen_const",   out_rd_wen, 1);
        chk("x0_count_const", free_count, 29);
`endif

        k = 0;
        while (m_fl.size() > 0 && k < 64) begin
            issue("fill", k % 32, (k * 7) % 32, 1 + (k % 31), 1, 0, 0);
            k++;
        end
        chk("empty_free_count", free_count, 0);
        set_in(0, 1, 2, 3, 1);
        #1;
        chk("empty_ready_wen1", in_ready, 0);
        set_in(0, 1, 2, 3, 0);
        #1;
        chk("empty_ready_wen0", in_ready, 1);

        set_in(1, 3, 3, 3, 1);
        free_valid = 1'b1;
        free_preg  = 6'd7;
        #1;
        chk("nobypass_ready", in_ready, 0);
        tick();
        free_valid = 1'b0;
        m_fl.push_back(7);
        #1;
        chk("after_free_count", free_count, 1);
        chk("after_free_ready", in_ready,   1);
        model_accept(3, 3, 3, 1, alloc);
        tick();
        in_valid = 1'b0;
        check_out("realloc");
        chk("realloc_prd_const", out_prd, 7);

        free_only("fr50", 50);
        free_only("fr51", 51);
        issue("hold_a", 1, 2, 3, 1, 0, 0);
        out_ready = 1'b0;
        set_in(1, 4, 5, 6, 1);
        #1;
        chk("stall_in_ready", in_ready, 0);
        tick();
        tick();
        chk("stall_valid",  out_valid,   1);
        chk("stall_prs1",   out_prs1,    last_exp.prs1);
        chk("stall_prd",    out_prd,     last_exp.prd);
        chk("stall_old",    out_old_prd, last_exp.old_prd);
        chk("stall_count",  free_count,  m_fl.size());
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", in_ready, 1);
        model_accept(4, 5, 6, 1, alloc);
        tick();
        in_valid = 1'b0;
        check_out("hold_b");

        free_only("fr52", 52);
        k = m_fl.size();
        issue("simul", 7, 8, 9, 1, 1, 44);
        chk("simul_count_same", free_count, k);
        issue("simul_next", 9, 9, 10, 1, 0, 0);

        set_in(1, 1, 1, 1, 1);
        free_valid = 1'b1;
        free_preg  = 6'd20;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        in_valid   = 1'b0;
        free_valid = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", out_valid,   0);
        chk("mid_rst_prd",   out_prd,     0);
        chk("mid_rst_prs1",  out_prs1,    0);
        chk("mid_rst_old",   out_old_prd, 0);
        chk("mid_rst_count", free_count,  32);

        free_only("full_ignore", 9);
        chk("full_ignore_const", free_count, 32);
        issue("post_rst", 5, 1, 5, 1, 0, 0);
        chk("post_rst_prd_const", out_prd,  32);
        chk("post_rst_prs1_const", out_prs1, 5);

        tick();
        chk("drain_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
